// File: rtl/mul43_pkg.sv
// mul43_pkg: shared widths and state type for the MUL43 arithmetic chain.
//   X_W / Y_W : operand widths of the 4x3 multiplier
//   P_W       : product width
//   mac_state_t : accumulator stage states (ACC, DRAIN, DONE)
package mul43_pkg;
    localparam int X_W = 4;
    localparam int Y_W = 3;
    localparam int P_W = 7;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mac_state_t;
endpackage

// File: rtl/mul_acc43_if.sv
// mul_acc43_if: operand input and result output handshakes of mul_acc43.
//   in_valid/in_ready/x/y           : operand pair stream
//   out_valid/out_ready/sum/ovf     : accumulated result
//   master : producer/consumer side, slave : the accumulator block
interface mul_acc43_if
    import mul43_pkg::*;
#(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, sum, ovf
    );
    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/mul_acc43_mul43.sv
// MUL43: combinational 4x3 unsigned multiplier.
//   X : 4-bit multiplicand, Y : 3-bit multiplier, P : 7-bit product
module MUL43
    import mul43_pkg::*;
(
    input  logic [X_W-1:0] X,
    input  logic [Y_W-1:0] Y,
    output logic [P_W-1:0] P
);
    assign P = P_W'(X) * P_W'(Y);
endmodule

// File: rtl/mul_acc43.sv
// mul_acc43: accumulates N consecutive MUL43 products and hands the total
// out on a valid/ready port.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any accumulation)
//   bus : mul_acc43_if slave (operand stream in, sum/ovf result out)
// Build option: define MUL_ACC_SAT_EN to clamp the sum at 2^ACC_W-1
// instead of wrapping. OVF is sticky until the result handshake or reset.
module mul_acc43
    import mul43_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 12
) (
    input  logic       clk,
    input  logic       rst,
    mul_acc43_if.slave bus
);
    localparam int CNT_W = $clog2(N + 1);

    mac_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             op_valid;
    logic [X_W-1:0]   op_x;
    logic [Y_W-1:0]   op_y;
    logic [P_W-1:0]   prod;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             out_fire;

    MUL43 u_mul43 (
        .X (op_x),
        .Y (op_y),
        .P (prod)
    );

    // Extra top bit captures the carry out of the accumulator.
    assign sum_ext  = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = (state == DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && count == CNT_W'(N - 1)) state_nxt = DRAIN;
            DRAIN:   if (op_valid) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACC) && (count < CNT_W'(N)) && !rst;
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            op_valid <= 1'b0;
            op_x     <= '0;
            op_y     <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            // op_valid tracks whether the operand registers hold a fresh pair.
            op_valid <= accept;
            if (accept) begin
                op_x  <= bus.x;
                op_y  <= bus.y;
                count <= count + 1'b1;
            end
            if (out_fire) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (op_valid) begin
`ifdef MUL_ACC_SAT_EN
                if (sum_ext[ACC_W]) begin
                    acc <= '1;
                    ovf <= 1'b1;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                end
`else
                acc <= sum_ext[ACC_W-1:0];
                if (sum_ext[ACC_W]) ovf <= 1'b1;
`endif
            end
        end
    end

    assign bus.sum = acc;
    assign bus.ovf = ovf;
endmodule
